sequence_player: RTL

SEQUENCE_PLAYER -- requirements
Module: sequence_player

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_ram.sv | 25 ++
 rtl/sequence_player.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence player.
package seq_pkg;

   localparam int unsigned STEP_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Width of a down-counter that must hold max(a, b) - 1.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/seq_ram.sv
// Step storage: one synchronous write port, one asynchronous read port.
module seq_ram
   import seq_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              Clock,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [STEP_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [STEP_W-1:0] rdata
);

   logic [STEP_W-1:0] mem [DEPTH];

   // Contents are intentionally not reset; length tracks which entries are valid.
   always_ff @(posedge Clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sequence_player.sv
// Records 2-bit steps and plays them back, each shown for ON_CYCLES then blanked for GAP_CYCLES.
module sequence_player
   import seq_pkg::*;
#(
   parameter  int unsigned DEPTH      = 16,
   parameter  int unsigned ON_CYCLES  = 4,
   parameter  int unsigned GAP_CYCLES = 2,
   localparam int unsigned AW         = $clog2(DEPTH),
   localparam int unsigned LW         = AW + 1
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic [2:0]        rand_in,
   input  logic              append,
   input  logic              clear,
   input  logic              play,
   output logic [STEP_W-1:0] step_out,
   output logic              step_valid,
   output logic              busy,
   output logic [LW-1:0]     length,
   output logic              full,
   output logic              play_done
);

   localparam int unsigned CW = cnt_width(ON_CYCLES, GAP_CYCLES);

   logic [1:0]        rst_sync;
   logic              rst_n;
   state_t            state, state_d;
   logic [AW-1:0]     index, index_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [LW-1:0]     length_d;
   logic [STEP_W-1:0] step_out_d;
   logic              step_valid_d, busy_d, full_d, play_done_d;
   logic              we_c, last_c;
   logic [AW-1:0]     raddr_c;
   logic [STEP_W-1:0] rdata_c;
   logic              unused_rand;

   assign unused_rand = rand_in[2];

   // Reset asserts immediately, releases two clock edges later.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   // Entry 0 is read when starting from IDLE, the following entry when leaving GAP.
   assign raddr_c = (state == GAP) ? index + AW'(1) : '0;
   assign last_c  = (LW'(index) + LW'(1)) >= length;

   seq_ram #(.DEPTH(DEPTH)) u_ram (
      .Clock (Clock),
      .we    (we_c),
      .waddr (length[AW-1:0]),
      .wdata (rand_in[STEP_W-1:0]),
      .raddr (raddr_c),
      .rdata (rdata_c)
   );

   // Next-state and next-output logic; clear overrides everything.
   always_comb begin
      state_d      = state;
      index_d      = index;
      cnt_d        = cnt;
      length_d     = length;
      step_out_d   = step_out;
      step_valid_d = step_valid;
      play_done_d  = 1'b0;
      we_c         = 1'b0;

      if (clear) begin
         state_d      = IDLE;
         length_d     = '0;
         step_out_d   = '0;
         step_valid_d = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (play) begin
                  if (length != '0) begin
                     state_d      = SHOW;
                     index_d      = '0;
                     cnt_d        = CW'(ON_CYCLES - 1);
                     step_out_d   = rdata_c;
                     step_valid_d = 1'b1;
                  end else begin
                     play_done_d = 1'b1;
                  end
               end else if (append && !full) begin
                  we_c     = 1'b1;
                  length_d = length + LW'(1);
               end
            end
            SHOW: begin
               if (cnt == '0) begin
                  state_d      = GAP;
                  cnt_d        = CW'(GAP_CYCLES - 1);
                  step_out_d   = '0;
                  step_valid_d = 1'b0;
               end else begin
                  cnt_d = cnt - CW'(1);
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  if (last_c) begin
                     state_d     = IDLE;
                     play_done_d = 1'b1;
                  end else begin
                     state_d      = SHOW;
                     index_d      = index + AW'(1);
                     cnt_d        = CW'(ON_CYCLES - 1);
                     step_out_d   = rdata_c;
                     step_valid_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt - CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
      full_d = (length_d == LW'(DEPTH));
   end

   // State and output registers.
   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         index      <= '0;
         cnt        <= '0;
         length     <= '0;
         step_out   <= '0;
         step_valid <= 1'b0;
         busy       <= 1'b0;
         full       <= 1'b0;
         play_done  <= 1'b0;
      end else begin
         state      <= state_d;
         index      <= index_d;
         cnt        <= cnt_d;
         length     <= length_d;
         step_out   <= step_out_d;
         step_valid <= step_valid_d;
         busy       <= busy_d;
         full       <= full_d;
         play_done  <= play_done_d;
      end
   end

endmodule
